// File: rtl/tx_frame_source.sv
// tx_frame_source: buffered frame source feeding a tx encoder.
// Bytes are queued as {last, bits, data} entries and presented either a whole
// byte per req (BY_BYTE=1) or one bit per req, LSB first (BY_BYTE=0).
module tx_frame_source #(
   parameter int BY_BYTE = 1,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [7:0]                            wr_data,
   input  logic [2:0]                            wr_bits,
   input  logic                                  wr_last,
   input  logic                                  wr_valid,
   output logic                                  wr_ready,
   output logic [((BY_BYTE != 0) ? 8 : 1)-1:0]   tx_data,
   output logic                                  tx_data_valid,
   output logic [2:0]                            tx_data_bits,
   output logic                                  tx_last_bit_in_byte,
   input  logic                                  tx_req,
   output logic                                  frame_done,
   output logic                                  underrun,
   output logic                                  timeout,
   output logic                                  busy
);
   localparam int TW = (BY_BYTE != 0) ? 8 : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit BYTE_MODE = (BY_BYTE != 0);
   localparam bit TO_EN = (TIMEOUT > 0);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SEND  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [11:0]   mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_s, count_d_s;
   logic [11:0]   head_s, ent_q, ent_d, ld_ent_s;
   logic          push_s, pop_s, empty_s, ld_en_s, ld_first_s;
   logic [7:0]    data_q, data_d;
   logic [3:0]    rem_q, rem_d;
   logic [2:0]    bits_q, bits_d;
   logic          lbit_q, lbit_d, last_q, last_d, valid_q, valid_d;
   logic          done_q, done_d, under_q, under_d, to_q, to_d;
   logic          ready_q, ready_d, busy_q, busy_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Number of bit items in a byte: the first byte of a frame may be partial.
   function automatic logic [3:0] item_count(input logic [2:0] bits, input logic first);
      if (first && (bits != 3'd0)) begin
         return {1'b0, bits};
      end else begin
         return 4'd8;
      end
   endfunction

   assign push_s  = wr_valid & ready_q;
   assign count_s = wr_ptr_q - rd_ptr_q;
   assign empty_s = (count_s == '0);
   assign head_s  = mem_q[rd_ptr_q[AW-1:0]];

   // Store accepted bytes; pointers qualify the contents, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {wr_last, wr_bits, wr_data};
      end
   end

   // Frame sequencing: pop/prefetch control, item stepping and error exits.
   always_comb begin
      state_d    = state_q;
      ent_d      = ent_q;
      data_d     = data_q;
      rem_d      = rem_q;
      bits_d     = bits_q;
      lbit_d     = lbit_q;
      last_d     = last_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      under_d    = 1'b0;
      to_d       = 1'b0;
      pop_s      = 1'b0;
      ld_en_s    = 1'b0;
      ld_first_s = 1'b0;
      ld_ent_s   = head_s;
      case (state_q)
         IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               ent_d   = head_s;
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            ld_en_s    = 1'b1;
            ld_first_s = 1'b1;
            ld_ent_s   = ent_q;
            valid_d    = 1'b1;
            state_d    = SEND;
         end
         SEND: begin
            if (valid_q && tx_req) begin
               if (!BYTE_MODE && (rem_q > 4'd1)) begin
                  data_d = {1'b0, data_q[7:1]};
                  rem_d  = rem_q - 4'd1;
                  lbit_d = (rem_q == 4'd2);
               end else if (last_q) begin
                  done_d  = 1'b1;
                  valid_d = 1'b0;
                  bits_d  = 3'd0;
                  lbit_d  = 1'b0;
                  state_d = IDLE;
               end else if (!empty_s) begin
                  pop_s   = 1'b1;
                  ld_en_s = 1'b1;
               end else begin
                  under_d = 1'b1;
                  valid_d = 1'b0;
                  bits_d  = 3'd0;
                  lbit_d  = 1'b0;
                  state_d = FLUSH;
               end
            end else if (TO_EN && valid_q && (cnt_q == TO_LAST)) begin
               to_d    = 1'b1;
               valid_d = 1'b0;
               bits_d  = 3'd0;
               lbit_d  = 1'b0;
               // A timed-out final entry leaves nothing of the frame to flush.
               state_d = last_q ? IDLE : FLUSH;
            end else begin
               state_d = SEND;
            end
         end
         FLUSH: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               state_d = head_s[11] ? IDLE : FLUSH;
            end else begin
               state_d = FLUSH;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase

      if (ld_en_s) begin
         data_d = ld_ent_s[7:0];
         last_d = ld_ent_s[11];
         if (BYTE_MODE) begin
            rem_d  = 4'd1;
            lbit_d = 1'b0;
            bits_d = ld_first_s ? ld_ent_s[10:8] : 3'd0;
         end else begin
            rem_d  = item_count(ld_ent_s[10:8], ld_first_s);
            lbit_d = (item_count(ld_ent_s[10:8], ld_first_s) == 4'd1);
            bits_d = 3'd0;
         end
      end else begin
         ld_first_s = 1'b0;
      end
   end

   // Pointer, occupancy-derived flag and req-timeout counter updates.
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + (AW + 1)'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + (AW + 1)'(1)) : rd_ptr_q;
      count_d_s = wr_ptr_d - rd_ptr_d;
      ready_d   = (count_d_s != FULL_CNT);
      busy_d    = (state_d != IDLE) || (count_d_s != '0);
      if (!TO_EN || !valid_q || tx_req) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // State and output registers; reset discards any frame in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ent_q    <= 12'd0;
         data_q   <= 8'd0;
         rem_q    <= 4'd0;
         bits_q   <= 3'd0;
         lbit_q   <= 1'b0;
         last_q   <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         under_q  <= 1'b0;
         to_q     <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ent_q    <= ent_d;
         data_q   <= data_d;
         rem_q    <= rem_d;
         bits_q   <= bits_d;
         lbit_q   <= lbit_d;
         last_q   <= last_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         under_q  <= under_d;
         to_q     <= to_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   assign wr_ready            = ready_q;
   assign tx_data             = data_q[TW-1:0];
   assign tx_data_valid       = valid_q;
   assign tx_data_bits        = bits_q;
   assign tx_last_bit_in_byte = lbit_q;
   assign frame_done          = done_q;
   assign underrun            = under_q;
   assign timeout             = to_q;
   assign busy                = busy_q;
endmodule

// File: tb/tb_tx_frame_source.sv
// Directed scoreboard bench for tx_frame_source: byte mode with timeout,
// bit mode, and a shallow FIFO for the full/reset case.
module tb_tx_frame_source;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   // Instance A: byte mode, DEPTH 4, TIMEOUT 10
   logic [7:0] a_wd = 8'd0, a_data;
   logic [2:0] a_wb = 3'd0, a_bits;
   logic       a_wl = 1'b0, a_wv = 1'b0, a_req = 1'b0;
   logic       a_ready, a_valid, a_lbit, a_done, a_under, a_to, a_busy;
   // Instance B: bit mode, DEPTH 16, no timeout
   logic [7:0] b_wd = 8'd0;
   logic [2:0] b_wb = 3'd0, b_bits;
   logic       b_wl = 1'b0, b_wv = 1'b0, b_req = 1'b0;
   logic       b_data, b_ready, b_valid, b_lbit, b_done, b_under, b_to, b_busy;
   // Instance C: byte mode, DEPTH 4, no timeout, never requested
   logic [7:0] c_wd = 8'd0, c_data;
   logic [2:0] c_wb = 3'd0, c_bits;
   logic       c_wl = 1'b0, c_wv = 1'b0, c_req = 1'b0;
   logic       c_ready, c_valid, c_lbit, c_done, c_under, c_to, c_busy;

   logic [10:0] qa[$];   // {data, bits}
   logic [1:0]  qb[$];   // {bit, last_bit_in_byte}

   always #5 clk = ~clk;

   tx_frame_source #(.BY_BYTE(1), .DEPTH(4), .TIMEOUT(10)) u_a (
      .clk(clk), .rst(rst), .wr_data(a_wd), .wr_bits(a_wb), .wr_last(a_wl),
      .wr_valid(a_wv), .wr_ready(a_ready), .tx_data(a_data), .tx_data_valid(a_valid),
      .tx_data_bits(a_bits), .tx_last_bit_in_byte(a_lbit), .tx_req(a_req),
      .frame_done(a_done), .underrun(a_under), .timeout(a_to), .busy(a_busy));

   tx_frame_source #(.BY_BYTE(0), .DEPTH(16), .TIMEOUT(0)) u_b (
      .clk(clk), .rst(rst), .wr_data(b_wd), .wr_bits(b_wb), .wr_last(b_wl),
      .wr_valid(b_wv), .wr_ready(b_ready), .tx_data(b_data), .tx_data_valid(b_valid),
      .tx_data_bits(b_bits), .tx_last_bit_in_byte(b_lbit), .tx_req(b_req),
      .frame_done(b_done), .underrun(b_under), .timeout(b_to), .busy(b_busy));

   tx_frame_source #(.BY_BYTE(1), .DEPTH(4), .TIMEOUT(0)) u_c (
      .clk(clk), .rst(rst), .wr_data(c_wd), .wr_bits(c_wb), .wr_last(c_wl),
      .wr_valid(c_wv), .wr_ready(c_ready), .tx_data(c_data), .tx_data_valid(c_valid),
      .tx_data_bits(c_bits), .tx_last_bit_in_byte(c_lbit), .tx_req(c_req),
      .frame_done(c_done), .underrun(c_under), .timeout(c_to), .busy(c_busy));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic a_write(input logic [7:0] d, input logic [2:0] bits, input logic last);
      chk("a_wr_ready", a_ready, 1'b1);
      a_wd = d; a_wb = bits; a_wl = last; a_wv = 1'b1;
      tick();
      a_wv = 1'b0;
   endtask

   task automatic b_write(input logic [7:0] d, input logic [2:0] bits, input logic last);
      b_wd = d; b_wb = bits; b_wl = last; b_wv = 1'b1;
      tick();
      b_wv = 1'b0;
   endtask

   // Expected bit items of one byte: n bits LSB first, last flag on bit n-1.
   task automatic b_expect(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) qb.push_back({d[i], (i == n - 1) ? 1'b1 : 1'b0});
   endtask

   // Wait (bounded) for a valid item, compare with the scoreboard, then req it.
   task automatic a_take(input int max_wait, input int gap, input bit fin);
      logic [10:0] exp;
      int w = 0;
      while (a_valid !== 1'b1 && w < max_wait) begin tick(); w++; end
      chk("a_valid_wait", a_valid, 1'b1);
      exp = (qa.size() > 0) ? qa.pop_front() : 11'h7FF;
      chk("a_item", {a_data, a_bits, a_lbit}, {exp, 1'b0});
      repeat (gap) tick();
      a_req = 1'b1; tick(); a_req = 1'b0;
      if (fin) begin
         chk("a_frame_done", {a_done, a_valid}, 2'b10);
         tick();
         chk("a_done_pulse", {a_done, a_valid}, 2'b00);
      end
   endtask

   task automatic b_take(input int max_wait, input int gap, input bit fin);
      logic [1:0] exp;
      int w = 0;
      while (b_valid !== 1'b1 && w < max_wait) begin tick(); w++; end
      chk("b_valid_wait", b_valid, 1'b1);
      exp = (qb.size() > 0) ? qb.pop_front() : 2'bxx;
      chk("b_item", {b_data, b_lbit, b_bits}, {exp, 3'b000});
      repeat (gap) tick();
      b_req = 1'b1; tick(); b_req = 1'b0;
      if (fin) begin
         chk("b_frame_done", {b_done, b_valid}, 2'b10);
         tick();
         chk("b_done_pulse", {b_done, b_valid}, 2'b00);
      end
   endtask

   initial begin
      // Reset state
      tick(); tick();
      chk("a_reset", {a_ready, a_valid, a_data, a_bits, a_lbit, a_done, a_under, a_to, a_busy}, {1'b1, 17'd0});
      chk("b_reset", {b_ready, b_valid, b_data, b_bits, b_lbit, b_done, b_under, b_to, b_busy}, {1'b1, 10'd0});
      rst = 1'b0;
      tick();

      // A: three-byte frame, req every 4 cycles; first byte appears 3 cycles after its write
      qa.push_back({8'hA5, 3'd0}); qa.push_back({8'h3C, 3'd0}); qa.push_back({8'h81, 3'd0});
      a_write(8'hA5, 3'd0, 1'b0);
      a_write(8'h3C, 3'd0, 1'b0);
      chk("a_latency_early", a_valid, 1'b0);
      a_write(8'h81, 3'd0, 1'b1);
      chk("a_latency", a_valid, 1'b1);
      a_take(0, 3, 1'b0);
      a_take(0, 3, 1'b0);
      a_take(0, 3, 1'b1);
      chk("a_idle_after_frame", {a_valid, a_busy}, 2'b00);

      // A: partial first byte; bits on a later byte are ignored
      qa.push_back({8'h05, 3'd3}); qa.push_back({8'hFF, 3'd0});
      a_write(8'h05, 3'd3, 1'b0);
      a_write(8'hFF, 3'd5, 1'b1);
      a_take(5, 0, 1'b0);
      a_take(0, 0, 1'b1);

      // A: no req -> timeout 10 cycles after valid rises, rest of frame flushed
      a_write(8'h11, 3'd0, 1'b0);
      a_write(8'h22, 3'd0, 1'b0);
      a_write(8'h33, 3'd0, 1'b1);
      begin
         int w = 0;
         while (a_valid !== 1'b1 && w < 10) begin tick(); w++; end
      end
      chk("a_to_start", {a_valid, a_data}, {1'b1, 8'h11});
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k < 10) chk("a_to_hold", {a_valid, a_to}, 2'b10);
         else        chk("a_to_fire", {a_valid, a_to}, 2'b01);
      end
      tick();
      chk("a_to_pulse", {a_to, a_valid, a_done}, 3'b000);
      repeat (4) tick();
      chk("a_flushed", {a_busy, a_valid, a_done}, 3'b000);
      qa.push_back({8'h44, 3'd0}); qa.push_back({8'h55, 3'd0});
      a_write(8'h44, 3'd0, 1'b0);
      a_write(8'h55, 3'd0, 1'b1);
      a_take(5, 3, 1'b0);
      a_take(0, 3, 1'b1);

      // B: bit mode, 3-bit first byte then a full byte
      b_expect(8'h05, 3);
      b_expect(8'hC3, 8);
      b_write(8'h05, 3'd3, 1'b0);
      b_write(8'hC3, 3'd0, 1'b1);
      for (int i = 0; i < 11; i++) b_take((i == 0) ? 5 : 0, 1, (i == 10));

      // B: single non-last byte -> underrun after its 8 bits, then flush
      b_expect(8'h5A, 8);
      b_write(8'h5A, 3'd0, 1'b0);
      for (int i = 0; i < 8; i++) b_take((i == 0) ? 5 : 0, 1, 1'b0);
      chk("b_underrun", {b_under, b_valid, b_done}, 3'b100);
      tick();
      chk("b_underrun_pulse", {b_under, b_busy}, 2'b01);
      b_write(8'h00, 3'd0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("b_flush_quiet", {b_valid, b_done}, 2'b00);
         tick();
      end
      chk("b_flushed", {b_busy, b_valid}, 2'b00);
      chk("b_queue_empty", qb.size(), 0);

      // C: fill with no req. The first byte moves into the output stage,
      // so the 4-entry FIFO fills on the 5th accepted byte.
      for (int i = 0; i < 5; i++) begin
         chk("c_ready_free", c_ready, 1'b1);
         c_wd = 8'h10 + 8'(i); c_wv = 1'b1;
         tick();
      end
      chk("c_ready_full", c_ready, 1'b0);
      c_wd = 8'hEE;
      tick();
      c_wv = 1'b0;
      chk("c_holding", {c_ready, c_valid, c_data, c_busy}, {1'b0, 1'b1, 8'h10, 1'b1});

      // Reset mid-frame: asynchronous return to reset values
      #2 rst = 1'b1;
      #1;
      chk("c_reset", {c_ready, c_valid, c_data, c_bits, c_lbit, c_done, c_under, c_to, c_busy}, {1'b1, 17'd0});
      chk("a_reset2", {a_ready, a_valid, a_busy}, 3'b100);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("c_post_reset", {c_ready, c_valid, c_done, c_busy}, 4'b1000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
